// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch: synchronised/debounced start and lap buttons drive an IDLE/RUN/PAUSE FSM.
// Define LAP_EN to build the lap-hold display freeze; otherwise lap_active is tied low.
module stopwatch_core #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned DB_DIV   = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       running,
  output logic       lap_active
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DbW   = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [DbW-1:0]   DbMax   = DbW'(DB_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  // Button index 0 is start, index 1 is lap.
  logic [1:0]      sync1_q, sync2_q;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic            db_strobe;
  logic [1:0][3:0] sh_q, sh_d;
  logic [1:0]      lvl_q, lvl_d, lvl_prev_q;
  logic            start_p, lap_p;

  state_e           state_q, state_d;
  logic [TickW-1:0] presc_q, presc_d;
  logic             tick, clr_cnt;
  logic [3:0]       sec0_q, sec0_d, sec1_q, sec1_d, min0_q, min0_d, min1_q, min1_d;
  logic [15:0]      live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_lap, btn_start};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_strobe = (db_cnt_q == DbMax);
    db_cnt_d  = db_strobe ? '0 : db_cnt_q + DbW'(1);
  end

  // Level only moves once the last four strobe samples all agree.
  always_comb begin
    sh_d  = sh_q;
    lvl_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (db_strobe) sh_d[i] = {sh_q[i][2:0], sync2_q[i]};
      if (sh_q[i] == 4'b1111)      lvl_d[i] = 1'b1;
      else if (sh_q[i] == 4'b0000) lvl_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q   <= '0;
      sh_q       <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      sh_q       <= sh_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  assign start_p = lvl_q[0] & ~lvl_prev_q[0];
  assign lap_p   = lvl_q[1] & ~lvl_prev_q[1];

`ifdef LAP_EN
  logic        lap_clr, lap_tgl;
  logic        lap_q, lap_d;
  logic [15:0] hold_q, hold_d;
`endif

  // start_p is tested first everywhere, so it wins over a simultaneous lap_p.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick    = 1'b0;
    clr_cnt = 1'b0;
`ifdef LAP_EN
    lap_clr = 1'b0;
    lap_tgl = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (start_p) begin
          state_d = StRun;
          presc_d = '0;
        end
      end
      StRun: begin
        if (presc_q == TickMax) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + TickW'(1);
        end
        if (start_p) begin
          state_d = StPause;
`ifdef LAP_EN
          lap_clr = 1'b1;
        end else if (lap_p) begin
          lap_tgl = 1'b1;
`endif
        end
      end
      StPause: begin
        if (start_p) begin
          state_d = StRun;
        end else if (lap_p) begin
          state_d = StIdle;
          presc_d = '0;
          clr_cnt = 1'b1;
`ifdef LAP_EN
          lap_clr = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // BCD cascade; >= compares keep every digit in range even from a corrupted value.
  always_comb begin
    sec0_d = sec0_q;
    sec1_d = sec1_q;
    min0_d = min0_q;
    min1_d = min1_q;
    if (clr_cnt) begin
      sec0_d = '0;
      sec1_d = '0;
      min0_d = '0;
      min1_d = '0;
    end else if (tick) begin
      if (sec0_q >= 4'd9) begin
        sec0_d = '0;
        if (sec1_q >= 4'd5) begin
          sec1_d = '0;
          if (min0_q >= 4'd9) begin
            min0_d = '0;
            min1_d = (min1_q >= 4'd5) ? 4'd0 : min1_q + 4'd1;
          end else begin
            min0_d = min0_q + 4'd1;
          end
        end else begin
          sec1_d = sec1_q + 4'd1;
        end
      end else begin
        sec0_d = sec0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      sec0_q  <= '0;
      sec1_q  <= '0;
      min0_q  <= '0;
      min1_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec0_q  <= sec0_d;
      sec1_q  <= sec1_d;
      min0_q  <= min0_d;
      min1_q  <= min1_d;
    end
  end

  assign live = {min1_q, min0_q, sec1_q, sec0_q};

`ifdef LAP_EN
  // Latch the post-edge count so the frozen value matches what live would show.
  always_comb begin
    lap_d  = lap_q;
    hold_d = hold_q;
    if (lap_clr) begin
      lap_d = 1'b0;
    end else if (lap_tgl) begin
      lap_d = ~lap_q;
      if (!lap_q) hold_d = {min1_d, min0_d, sec1_d, sec0_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      lap_q  <= lap_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    {dig3, dig2, dig1, dig0} = lap_q ? hold_q : live;
    running                  = (state_q == StRun);
    lap_active               = lap_q;
  end
`else
  always_comb begin
    {dig3, dig2, dig1, dig0} = live;
    running                  = (state_q == StRun);
    lap_active               = 1'b0;
  end
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with TICK_DIV=10, DB_DIV=2; lap-hold checks need LAP_EN.
module tb_stopwatch_core;

  localparam int TickDiv = 10;

  logic       clk, rst_n, btn_start, btn_lap;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic       running, lap_active;
  logic [15:0] dig_all;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  stopwatch_core #(
    .TICK_DIV(TickDiv),
    .DB_DIV  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .dig3      (dig3),
    .dig2      (dig2),
    .dig1      (dig1),
    .dig0      (dig0),
    .running   (running),
    .lap_active(lap_active)
  );

  assign dig_all = {dig3, dig2, dig1, dig0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [1:0] ActWait   = 2'd0;
  localparam logic [1:0] ActBounce = 2'd1;

  typedef struct packed {
    logic [1:0]  act;
    logic [31:0] cycles;
    logic [15:0] dig;
    logic        run;
    logic        lap;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mkv(input logic [1:0] act, input int cycles, input logic [15:0] dig,
                               input logic run, input logic lap);
    vec_t v;
    v.act    = act;
    v.cycles = cycles;
    v.dig    = dig;
    v.run    = run;
    v.lap    = lap;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int secs);
    int s, m;
    s = secs % 3600;
    m = s / 60;
    s = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a button until the watched output reaches target, then release it.
  task automatic press(input bit use_lap, input bit watch_lap, input logic target,
                       input string name, output int edge_cyc);
    bit seen;
    seen = 1'b0;
    if (use_lap) btn_lap = 1'b1;
    else         btn_start = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if ((watch_lap ? lap_active : running) === target) seen = 1'b1;
    end
    edge_cyc  = cyc;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no response within 200 cycles, expected %0b", name, target);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] dig, input logic run,
                           input logic lap);
    check({name, " digits"}, 32'(dig_all), 32'(dig));
    check({name, " running"}, 32'(running), 32'(run));
    check({name, " lap_active"}, 32'(lap_active), 32'(lap));
  endtask

  initial begin
    int e_cyc, p_cyc, r_cyc, e2_cyc, l_cyc, p_rel, remaining;
    logic [15:0] paused;

    vecs[0] = mkv(ActWait,   0,     16'h0000, 1'b1, 1'b0);
    vecs[1] = mkv(ActWait,   9,     16'h0000, 1'b1, 1'b0);
    vecs[2] = mkv(ActWait,   1,     16'h0001, 1'b1, 1'b0);
    vecs[3] = mkv(ActWait,   90,    16'h0010, 1'b1, 1'b0);
    vecs[4] = mkv(ActBounce, 30,    16'h0013, 1'b1, 1'b0);
    vecs[5] = mkv(ActWait,   20,    16'h0015, 1'b1, 1'b0);
    vecs[6] = mkv(ActWait,   35840, 16'h5959, 1'b1, 1'b0);
    vecs[7] = mkv(ActWait,   9,     16'h5959, 1'b1, 1'b0);
    vecs[8] = mkv(ActWait,   1,     16'h0000, 1'b1, 1'b0);
    vecs[9] = mkv(ActWait,   10,    16'h0001, 1'b1, 1'b0);

    rst_n     = 1'b0;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    step(1);
    check_all("in_reset", 16'h0000, 1'b0, 1'b0);
    step(4);
    rst_n = 1'b1;
    step(200);
    check_all("idle", 16'h0000, 1'b0, 1'b0);

    // Vector timings are edges since the FSM entered RUN.
    press(1'b0, 1'b0, 1'b1, "start", e_cyc);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].act == ActBounce) begin
        for (int j = 0; j < int'(vecs[i].cycles); j++) begin
          btn_start = ((j / 3) % 2) == 0;
          step(1);
        end
        btn_start = 1'b0;
      end else begin
        step(int'(vecs[i].cycles));
      end
      check_all($sformatf("vec[%0d]", i), vecs[i].dig, vecs[i].run, vecs[i].lap);
    end

    // Pause around 00:07 and hold.
    step(55);
    press(1'b0, 1'b0, 1'b0, "pause", p_cyc);
    p_rel  = p_cyc - e_cyc;
    paused = to_bcd(p_rel / TickDiv);
    check_all("paused", paused, 1'b0, 1'b0);
    step(100);
    check_all("pause_hold", paused, 1'b0, 1'b0);

    // Resume: prescaler continues from where it stopped.
    press(1'b0, 1'b0, 1'b1, "resume", r_cyc);
    remaining = TickDiv - (p_rel % TickDiv);
    step(remaining - 1);
    check_all("resume_pre", paused, 1'b1, 1'b0);
    step(1);
    check_all("resume_tick", to_bcd(p_rel / TickDiv + 1), 1'b1, 1'b0);

    // Pause again, then lap clears to IDLE.
    step(30);
    press(1'b0, 1'b0, 1'b0, "pause2", p_cyc);
    step(30);
    btn_lap = 1'b1;
    step(30);
    btn_lap = 1'b0;
    step(30);
    check_all("cleared", 16'h0000, 1'b0, 1'b0);

    // From IDLE the prescaler restarts at zero.
    press(1'b0, 1'b0, 1'b1, "restart", e2_cyc);
    step(9);
    check_all("restart_pre", 16'h0000, 1'b1, 1'b0);
    step(1);
    check_all("restart_tick", 16'h0001, 1'b1, 1'b0);
    step(28);

`ifdef LAP_EN
    press(1'b1, 1'b1, 1'b1, "lap_set", l_cyc);
    paused = to_bcd((l_cyc - e2_cyc) / TickDiv);
    check_all("lap_set", paused, 1'b1, 1'b1);
    step(300);
    check_all("lap_frozen", paused, 1'b1, 1'b1);
    press(1'b1, 1'b1, 1'b0, "lap_clr", l_cyc);
    check_all("lap_clr", to_bcd((l_cyc - e2_cyc) / TickDiv), 1'b1, 1'b0);
    step(10);
    check_all("lap_live", to_bcd((cyc - e2_cyc) / TickDiv), 1'b1, 1'b0);
`else
    btn_lap = 1'b1;
    step(30);
    btn_lap = 1'b0;
    step(30);
    check_all("lap_ignored", to_bcd((cyc - e2_cyc) / TickDiv), 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-count, then no counting without a new start.
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 16'h0000, 1'b0, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(50);
    check_all("post_reset", 16'h0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
